skid_fifo: RTL and testbench
============================

# skid_fifo

Parametrised successor to the 2-entry skid buffer: a valid/ready elastic buffer of configurable depth whose `o_data`, `o_valid` and `i_ready` all come straight from flops. No combinational path from `o_ready` to `i_ready`. It adds occupancy reporting, an almost-full flag and a synchronous flush. It sits between pipeline stages where more than one word of slack is needed, for example to absorb multi-cycle downstream stalls or to cover credit round-trip latency.

## Interface

- `WORD_WIDTH`, 8: payload width in bits, ≥1.
- `DEPTH`, 4: total words held, output register included. Must be ≥2; `DEPTH`=2 is functionally equivalent to the existing skid buffer.
- `ALMOST_FULL`, `DEPTH`-1: `almost_full` asserts when the registered count is ≥ this value. Range 1..`DEPTH`.
- `CW`, localparam, `$clog2(DEPTH+1)`: width of `count`.

Ports:

- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `i_valid`  in  1  upstream word valid.
- `i_ready`  out  1  registered; high when a word can be accepted.
- `i_data`  in  `WORD_WIDTH`  upstream payload.
- `o_valid`  out  1  registered; output word valid.
- `o_ready`  in  1  downstream accepts.
- `o_data`  out  `WORD_WIDTH`  registered head-of-queue payload.
- `flush`  in  1  synchronous discard of all held words.
- `count`  out  `CW`  registered number of held words, 0..`DEPTH`.
- `almost_full`  out  1  registered, equals (`count` ≥ `ALMOST_FULL`).

## Operation

- insert = `i_valid` & `i_ready`; remove = `o_valid` & `o_ready`.
- Storage is the output register plus a ring of `DEPTH`-1 entries (head and tail pointers, wrap modulo `DEPTH`-1).
- count_next = count + insert − remove. Simultaneous insert and remove leaves count unchanged.
- Output register load, in priority order:
  - When the output register is empty or being removed and the ring is non-empty, the ring head moves into the output register (head pointer advances).
  - Otherwise, if insert occurs, `i_data` goes directly into the output register.
- Ring write: an inserted word goes to the ring tail when it cannot go to the output register. That is, when the ring is non-empty, or when the output register is held and not removed.
- Words leave in strict insertion order. No word is duplicated or dropped, except by `flush`.
- Next-state flop values:
  - `i_ready` ← (count_next < `DEPTH`).
  - `o_valid` ← (count_next ≠ 0).
  - `almost_full` ← (count_next ≥ `ALMOST_FULL`).
- `flush` takes priority over insert and remove in the same cycle. On the next cycle:
  - count = 0, `o_valid` = 0, `i_ready` = 1, `almost_full` = 0.
  - Both pointers return to 0.
  - Any word inserted in the flush cycle is discarded.
  - `o_data` retains its value.
- Occupancy states:
  - EMPTY (count 0) → PARTIAL or stays on insert.
  - PARTIAL (0 < count < `DEPTH`) → any state.
  - FULL (count = `DEPTH`) → PARTIAL only via remove, or → EMPTY via flush.
- The state is derived from `count`; there is no separate state register.
- `o_data`/`o_valid` must stay stable while `o_valid` & !`o_ready`. The block requires upstream to do the same while `i_valid` & !`i_ready`.

## Timing

- Reset values: `i_ready`=1, `o_valid`=0, `o_data`=0, `count`=0, `almost_full`=0, pointers 0.
- Latency: a word inserted into an empty buffer appears with `o_valid`=1 on the next cycle.
- Throughput: one word per cycle sustained when `o_ready` stays high (flow), at any occupancy.
- FULL → remove: `i_ready` rises the cycle after the remove.
- Inserting into count `DEPTH`-1 with no remove: `i_ready` falls the following cycle. The accepted word is kept.
- Reset asserted mid-operation: all contents are discarded and reset values appear the next cycle.
- `flush` held for multiple cycles: the buffer stays EMPTY and rejects nothing visibly, but every insert is dropped.

## Structure

- Package `skid_pkg`: occupancy enum `skid_occ_t` {EMPTY, PARTIAL, FULL}, used for debug and formal, plus a count-width helper function.
- Sub-module `skid_ring_store`: `DEPTH`-1 × `WORD_WIDTH` register array with wrapping head and tail pointers, write and read-advance enables, and reset of the pointers only.
- Top level: output register, the count/flag flops, and load/write steering.
- The `FORMAL` block must include:
  - output stability under stall;
  - `count` ≤ `DEPTH`;
  - `i_ready` == (`count` < `DEPTH`);
  - order checking using a tagged word.

## Test plan

- Reset then idle (`DEPTH`=4, `WORD_WIDTH`=8): `i_ready`=1, `o_valid`=0, `count`=0, `o_data`=0x00.
- With `o_ready`=0, insert 0x01..0x04: `count` goes 1..4, `i_ready`=0 after the 4th insert, `almost_full`=1 from `count`=3, `o_data`=0x01 held stable.
- From FULL, raise `o_ready` for 4 cycles: outputs 0x01, 0x02, 0x03, 0x04 in order, `i_ready`=1 one cycle after the first remove, `o_valid`=0 after the last.
- Stream 0x10..0x2F with `o_ready`=1 throughout: one word per cycle, `count` steady at 1, identical sequence out, 1-cycle latency.
- Random `o_ready` (50%) over 1000 incrementing words: no loss or reorder, and the ring pointers wrap at least 100 times.
- With `count`=3, assert `flush` together with an insert of 0x55: the next cycle shows `count`=0, `o_valid`=0, `i_ready`=1, and 0x55 never appears at the output.

Source files
------------

// File: rtl/skid_pkg.sv
// Shared types and sizing helpers for the skid FIFO and its ring store.
package skid_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } skid_occ_t;

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

endpackage

// File: rtl/skid_ring_store.sv
// Circular register array behind the output register; pointers wrap at ENTRIES.
module skid_ring_store
  import skid_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned ENTRIES    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic                  rd_adv,
  output logic [WORD_WIDTH-1:0] rd_data
);

  localparam int unsigned PW = ptr_width(ENTRIES);

  logic [WORD_WIDTH-1:0] mem [ENTRIES];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(ENTRIES - 1)) ? '0 : p + PW'(1);
  endfunction

  // Only the pointers are reset; stale array contents are never read.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (wr_en)  tail <= next_ptr(tail);
      if (rd_adv) head <= next_ptr(head);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[tail] <= wr_data;
  end

  assign rd_data = mem[head];

endmodule

// File: rtl/skid_fifo.sv
// Elastic valid/ready buffer of DEPTH words with fully registered handshake
// outputs; the output register is the head slot, the ring holds the rest.
module skid_fifo
  import skid_pkg::*;
#(
  parameter int unsigned WORD_WIDTH  = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ALMOST_FULL = DEPTH - 1,
  localparam int unsigned CW         = count_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [WORD_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [WORD_WIDTH-1:0] o_data,
  input  logic                  flush,
  output logic [CW-1:0]         count,
  output logic                  almost_full
);

  logic                  insert;
  logic                  remove;
  logic                  ring_has;
  logic                  out_free;
  logic                  load_ring;
  logic                  load_in;
  logic                  ring_wr;
  logic [CW-1:0]         count_next;
  logic [WORD_WIDTH-1:0] ring_data;

  // Output register is occupied whenever count is non-zero, so the ring
  // holds count-1 words and is non-empty from count 2 upward.
  always_comb begin
    insert     = i_valid & i_ready;
    remove     = o_valid & o_ready;
    ring_has   = (count >= CW'(2));
    out_free   = ~o_valid | remove;
    load_ring  = 1'b0;
    load_in    = 1'b0;
    ring_wr    = 1'b0;
    count_next = count + CW'(insert) - CW'(remove);
    if (flush) begin
      count_next = '0;
    end else begin
      load_ring = out_free & ring_has;
      load_in   = out_free & ~ring_has & insert;
      ring_wr   = insert & (ring_has | ~out_free);
    end
  end

  skid_ring_store #(
    .WORD_WIDTH (WORD_WIDTH),
    .ENTRIES    (DEPTH - 1)
  ) u_ring (
    .clk     (clk),
    .reset   (reset),
    .clear   (flush),
    .wr_en   (ring_wr),
    .wr_data (i_data),
    .rd_adv  (load_ring),
    .rd_data (ring_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      i_ready     <= 1'b1;
      o_valid     <= 1'b0;
      o_data      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
    end else begin
      count       <= count_next;
      i_ready     <= (count_next < CW'(DEPTH));
      o_valid     <= (count_next != '0);
      almost_full <= (count_next >= CW'(ALMOST_FULL));
      if (load_ring)    o_data <= ring_data;
      else if (load_in) o_data <= i_data;
    end
  end

`ifdef FORMAL
  skid_occ_t occ;
  assign occ = (count == '0) ? EMPTY : (count == CW'(DEPTH)) ? FULL : PARTIAL;

  assume property (@(posedge clk) disable iff (reset)
    (i_valid && !i_ready && !flush) |=> (i_valid && $stable(i_data)));

  a_out_stable: assert property (@(posedge clk) disable iff (reset)
    (o_valid && !o_ready && !flush) |=> (o_valid && $stable(o_data)));
  a_count_max: assert property (@(posedge clk) disable iff (reset)
    count <= CW'(DEPTH));
  a_ready_cnt: assert property (@(posedge clk) disable iff (reset)
    i_ready == (count < CW'(DEPTH)));
  a_full_exit: assert property (@(posedge clk) disable iff (reset)
    (occ == FULL && !flush) |=> (occ != EMPTY));

  // Order check: the first all-ones word in must be the tag_seq-th word out.
  localparam logic [WORD_WIDTH-1:0] TAG = '1;
  logic [31:0] in_seq, out_seq, tag_seq;
  logic        tag_armed;
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      in_seq <= '0; out_seq <= '0; tag_seq <= '0; tag_armed <= 1'b0;
    end else begin
      if (insert) in_seq <= in_seq + 32'd1;
      if (remove) out_seq <= out_seq + 32'd1;
      if (insert && i_data == TAG && !tag_armed) begin
        tag_armed <= 1'b1;
        tag_seq   <= in_seq;
      end else if (remove && tag_armed && out_seq == tag_seq) begin
        tag_armed <= 1'b0;
      end
    end
  end
  a_order: assert property (@(posedge clk) disable iff (reset || flush)
    (remove && tag_armed && out_seq == tag_seq) |-> (o_data == TAG));
`endif

endmodule

// File: tb/tb_skid_fifo.sv
// Self-checking bench for skid_fifo against a queue-based reference model.
module tb_skid_fifo;

  localparam int unsigned WW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AF    = DEPTH - 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          i_valid;
  logic          i_ready;
  logic [WW-1:0] i_data;
  logic          o_valid;
  logic          o_ready;
  logic [WW-1:0] o_data;
  logic          flush;
  logic [CW-1:0] count;
  logic          almost_full;

  always #5 clk = ~clk;

  skid_fifo #(
    .WORD_WIDTH  (WW),
    .DEPTH       (DEPTH),
    .ALMOST_FULL (AF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_valid     (i_valid),
    .i_ready     (i_ready),
    .i_data      (i_data),
    .o_valid     (o_valid),
    .o_ready     (o_ready),
    .o_data      (o_data),
    .flush       (flush),
    .count       (count),
    .almost_full (almost_full)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [WW-1:0] q[$];
  logic [WW-1:0] last_head;
  int            ring_writes;
  bit            saw_55;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    int sz = q.size();
    check("i_ready",     32'(i_ready),     32'(sz < int'(DEPTH)));
    check("o_valid",     32'(o_valid),     32'(sz != 0));
    check("count",       32'(count),       32'(sz));
    check("almost_full", 32'(almost_full), 32'(sz >= int'(AF)));
    check("o_data",      32'(o_data),      32'(last_head));
  endtask

  // One clock: drive inputs, check current state, advance the model.
  task automatic step(input bit iv, input logic [WW-1:0] id, input bit ordy,
                      input bit fl, output bit accepted);
    int sz;
    bit ins, rem;
    i_valid = iv;
    i_data  = id;
    o_ready = ordy;
    flush   = fl;
    @(negedge clk);
    compare_outputs();
    if (o_valid && o_ready && o_data == 8'h55) saw_55 = 1'b1;
    sz  = q.size();
    ins = iv && (sz < int'(DEPTH));
    rem = ordy && (sz != 0);
    if (fl) begin
      q.delete();
    end else begin
      if (ins && !(sz == 0 || (sz == 1 && rem))) ring_writes++;
      if (rem) void'(q.pop_front());
      if (ins) q.push_back(id);
    end
    if (q.size() > 0) last_head = q[0];
    accepted = ins && !fl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    o_ready = 1'b0;
    flush   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    last_head = '0;
  endtask

  initial begin
    bit acc;
    int word;
    int accepted_cnt;
    int cycles;

    ring_writes = 0;
    saw_55      = 1'b0;
    do_reset();

    // Reset then idle.
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0, acc);

    // Fill to FULL with downstream stalled, then hold.
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0, acc);
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0, acc);

    // Drain from FULL.
    repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    step(1'b0, 8'h00, 1'b0, 1'b0, acc);

    // Streaming flow-through.
    for (int i = 8'h10; i <= 8'h2F; i++) step(1'b1, 8'(i), 1'b1, 1'b0, acc);
    repeat (2) step(1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Random downstream stalls over 1000 incrementing words.
    word = 0;
    accepted_cnt = 0;
    cycles = 0;
    while (accepted_cnt < 1000 && cycles < 5000) begin
      step(1'b1, 8'(word), 1'($urandom % 2), 1'b0, acc);
      if (acc) begin
        word++;
        accepted_cnt++;
      end
      cycles++;
    end
    repeat (DEPTH + 2) step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    check("words_accepted", 32'(accepted_cnt), 32'd1000);
    check("ring_wraps_ge_100", 32'(ring_writes / int'(DEPTH - 1) >= 100), 32'd1);

    // Flush at count 3 together with an insert of 0x55.
    saw_55 = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, acc);
    step(1'b1, 8'h55, 1'b0, 1'b1, acc);
    repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    check("flush_drops_0x55", 32'(saw_55), 32'd0);

    // Held flush drops every insert.
    for (int i = 0; i < 2; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, acc);
    for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'($urandom % 2), 1'b1, acc);
    repeat (2) step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hD0 + i), 1'b1, 1'b0, acc);
    step(1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Reset mid-operation.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0, acc);
    do_reset();
    repeat (2) step(1'b0, 8'h00, 1'b1, 1'b0, acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
